// File: rtl/picorv_stream_mmio.sv
// picorv_stream_mmio: picorv32 native-bus window onto NUM_PORTS valid/ready
// stream channels. Each channel owns an RX FIFO (stream -> CPU), a TX FIFO
// (CPU -> stream), a STATUS register with sticky error flags and an IRQ_EN bit.
// Register map per channel p at BASE_ADDR + 16p: +0 DATA, +4 STATUS, +8 IRQ_EN.
module picorv_stream_mmio #(
   parameter int          NUM_PORTS  = 5,
   parameter int          DATA_WIDTH = 32,
   parameter int          DEPTH      = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
   parameter int          BLOCKING   = 1
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            bus_valid,
   input  logic [31:0]                     bus_addr,
   input  logic [31:0]                     bus_wdata,
   input  logic [3:0]                      bus_wstrb,
   output logic                            bus_hit,
   output logic                            bus_ready,
   output logic [31:0]                     bus_rdata,
   input  logic [NUM_PORTS-1:0]            val_in,
   output logic [NUM_PORTS-1:0]            ready_upward,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
   output logic [NUM_PORTS-1:0]            val_out,
   input  logic [NUM_PORTS-1:0]            ready_downward,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
   output logic                            irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RESP} state_e;
   typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_IRQ_EN, REG_RSVD} reg_e;

   state_e state;

   logic [DATA_WIDTH-1:0] rx_mem [NUM_PORTS][DEPTH];
   logic [DATA_WIDTH-1:0] tx_mem [NUM_PORTS][DEPTH];
   logic [AW-1:0]         rx_wr_ptr [NUM_PORTS];
   logic [AW-1:0]         rx_rd_ptr [NUM_PORTS];
   logic [AW-1:0]         tx_wr_ptr [NUM_PORTS];
   logic [AW-1:0]         tx_rd_ptr [NUM_PORTS];
   logic [CW-1:0]         rx_count  [NUM_PORTS];
   logic [CW-1:0]         tx_count  [NUM_PORTS];

   logic [NUM_PORTS-1:0] rx_not_empty, rx_full, tx_not_full;
   logic [NUM_PORTS-1:0] tx_drop, rx_underflow, irq_en;
   logic [NUM_PORTS-1:0] rx_push, rx_pop, tx_push, tx_pop;
   logic [NUM_PORTS-1:0] pop_req, push_req, under_req, drop_req;
   logic [NUM_PORTS-1:0] clr_drop, clr_under, irq_en_wr;
   logic [3:0]           port_idx;
   reg_e                 reg_sel;
   logic                 is_write, can_accept, accept;
   logic [31:0]          rdata_next;
   logic                 unused_addr_bits;

   assign bus_hit          = bus_valid && (bus_addr[31:8] == BASE_ADDR[31:8]);
   assign port_idx         = bus_addr[7:4];
   assign reg_sel          = reg_e'(bus_addr[3:2]);
   assign is_write         = |bus_wstrb;
   assign unused_addr_bits = &{1'b0, bus_addr[1:0]};

   // FIFO flags and stream-side handshakes derived from the registered counts
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         rx_not_empty[p] = (rx_count[p] != '0);
         rx_full[p]      = (rx_count[p] == CW'(DEPTH));
         tx_not_full[p]  = (tx_count[p] != CW'(DEPTH));
         val_out[p]      = resetn && (tx_count[p] != '0);
         ready_upward[p] = resetn && !rx_full[p];
         dout[p*DATA_WIDTH +: DATA_WIDTH] = tx_mem[p][tx_rd_ptr[p]];
      end
      rx_push = val_in & ready_upward;
      tx_pop  = val_out & ready_downward;
   end

   // Decode the current bus request into per-channel action requests and read data
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      can_accept = 1'b1;
      rdata_next = '0;
      pop_req    = '0;
      push_req   = '0;
      under_req  = '0;
      drop_req   = '0;
      clr_drop   = '0;
      clr_under  = '0;
      irq_en_wr  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (port_idx == 4'(p)) begin
            case (reg_sel)
               REG_DATA: begin
                  if (is_write) begin
                     if (tx_not_full[p])    push_req[p] = 1'b1;
                     else if (BLOCKING != 0) can_accept = 1'b0;
                     else                   drop_req[p] = 1'b1;
                  end else begin
                     if (rx_not_empty[p]) begin
                        pop_req[p] = 1'b1;
                        rdata_next = rx_mem[p][rx_rd_ptr[p]];
                     end else if (BLOCKING != 0) begin
                        can_accept = 1'b0;
                     end else begin
                        under_req[p] = 1'b1;
                     end
                  end
               end
               REG_STATUS: begin
                  if (is_write) begin
                     clr_drop[p]  = bus_wdata[2];
                     clr_under[p] = bus_wdata[3];
                  end else begin
                     rdata_next = {8'h00, 8'(tx_count[p]), 8'(rx_count[p]), 4'h0,
                                   rx_underflow[p], tx_drop[p], tx_not_full[p], rx_not_empty[p]};
                  end
               end
               REG_IRQ_EN: begin
                  if (is_write) irq_en_wr[p] = 1'b1;
                  else          rdata_next   = {31'h0, irq_en[p]};
               end
               default: ;
            endcase
         end
      end
      accept  = (state == ST_IDLE) && bus_hit && can_accept;
      rx_pop  = pop_req  & {NUM_PORTS{accept}};
      tx_push = push_req & {NUM_PORTS{accept}};
   end

   // Bus FSM: accept in IDLE when the action is possible, pulse bus_ready from RESP
   always_ff @(posedge clk) begin
      // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
      if (!resetn) begin
         state     <= ST_IDLE;
         bus_ready <= 1'b0;
         bus_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus_ready <= 1'b0;
               if (accept) begin
                  state     <= ST_RESP;
                  bus_ready <= 1'b1;
                  bus_rdata <= is_write ? 32'h0 : rdata_next;
               end
            end
            default: begin
               state     <= ST_IDLE;
               bus_ready <= 1'b0;
            end
         endcase
      end
   end

   // FIFO storage writes
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; empty FIFOs are defined by pointers and counts alone.
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rx_push[p]) rx_mem[p][rx_wr_ptr[p]] <= din[p*DATA_WIDTH +: DATA_WIDTH];
         if (tx_push[p]) tx_mem[p][tx_wr_ptr[p]] <= bus_wdata;
      end
   end

   // FIFO pointers and occupancy counts; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            rx_wr_ptr[p] <= '0;
            rx_rd_ptr[p] <= '0;
            tx_wr_ptr[p] <= '0;
            tx_rd_ptr[p] <= '0;
            rx_count[p]  <= '0;
            tx_count[p]  <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (rx_push[p]) rx_wr_ptr[p] <= rx_wr_ptr[p] + 1'b1;
            if (rx_pop[p])  rx_rd_ptr[p] <= rx_rd_ptr[p] + 1'b1;
            if (tx_push[p]) tx_wr_ptr[p] <= tx_wr_ptr[p] + 1'b1;
            if (tx_pop[p])  tx_rd_ptr[p] <= tx_rd_ptr[p] + 1'b1;
            case ({rx_push[p], rx_pop[p]})
               2'b10:   rx_count[p] <= rx_count[p] + 1'b1;
               2'b01:   rx_count[p] <= rx_count[p] - 1'b1;
               default: ;
            endcase
            case ({tx_push[p], tx_pop[p]})
               2'b10:   tx_count[p] <= tx_count[p] + 1'b1;
               2'b01:   tx_count[p] <= tx_count[p] - 1'b1;
               default: ;
            endcase
         end
      end
   end

   // Sticky flags (set wins over clear), IRQ enables and the registered interrupt
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tx_drop      <= '0;
         rx_underflow <= '0;
         irq_en       <= '0;
         irq          <= 1'b0;
      end else begin
         tx_drop      <= (tx_drop & ~(clr_drop & {NUM_PORTS{accept}}))
                         | (drop_req & {NUM_PORTS{accept}});
         rx_underflow <= (rx_underflow & ~(clr_under & {NUM_PORTS{accept}}))
                         | (under_req & {NUM_PORTS{accept}});
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept && irq_en_wr[p]) irq_en[p] <= bus_wdata[0];
         end
         irq <= |(irq_en & rx_not_empty);
      end
   end

endmodule

// File: tb/tb_picorv_stream_mmio.sv
// Directed bench for picorv_stream_mmio: one blocking instance (b_*) and one
// non-blocking instance (n_*), driven on negedges and sampled on negedges.
module tb_picorv_stream_mmio;

   localparam int          NP   = 5;
   localparam logic [31:0] BASE = 32'h2000_0000;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic            b_valid, b_hit, b_ready, b_irq;
   logic [31:0]     b_addr, b_wdata, b_rdata;
   logic [3:0]      b_wstrb;
   logic [NP-1:0]   b_val_in, b_rdy_up, b_val_out, b_rdy_dn;
   logic [NP*32-1:0] b_din, b_dout;

   logic            n_valid, n_hit, n_ready, n_irq;
   logic [31:0]     n_addr, n_wdata, n_rdata;
   logic [3:0]      n_wstrb;
   logic [NP-1:0]   n_val_in, n_rdy_up, n_val_out, n_rdy_dn;
   logic [NP*32-1:0] n_din, n_dout;

   int n_checks = 0;
   int n_errors = 0;

   picorv_stream_mmio #(.NUM_PORTS(NP), .DEPTH(8), .BASE_ADDR(BASE), .BLOCKING(1)) dut (
      .clk(clk), .resetn(resetn),
      .bus_valid(b_valid), .bus_addr(b_addr), .bus_wdata(b_wdata), .bus_wstrb(b_wstrb),
      .bus_hit(b_hit), .bus_ready(b_ready), .bus_rdata(b_rdata),
      .val_in(b_val_in), .ready_upward(b_rdy_up), .din(b_din),
      .val_out(b_val_out), .ready_downward(b_rdy_dn), .dout(b_dout), .irq(b_irq)
   );

   picorv_stream_mmio #(.NUM_PORTS(NP), .DEPTH(8), .BASE_ADDR(BASE), .BLOCKING(0)) dut_nb (
      .clk(clk), .resetn(resetn),
      .bus_valid(n_valid), .bus_addr(n_addr), .bus_wdata(n_wdata), .bus_wstrb(n_wstrb),
      .bus_hit(n_hit), .bus_ready(n_ready), .bus_rdata(n_rdata),
      .val_in(n_val_in), .ready_upward(n_rdy_up), .din(n_din),
      .val_out(n_val_out), .ready_downward(n_rdy_dn), .dout(n_dout), .irq(n_irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus access on the chosen instance; returns read data and cycles to bus_ready.
   task automatic bus_xfer(input bit nb, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output logic [31:0] rdata, output int cyc);
      bit done;
      done = 1'b0;
      cyc  = 0;
      rdata = '0;
      if (nb ? n_ready : b_ready) @(negedge clk);
      if (nb) begin n_valid = 1'b1; n_addr = addr; n_wdata = wdata; n_wstrb = wstrb; end
      else    begin b_valid = 1'b1; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb; end
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (nb ? n_ready : b_ready) begin
            done  = 1'b1;
            rdata = nb ? n_rdata : b_rdata;
         end
      end
      if (nb) begin n_valid = 1'b0; n_wstrb = 4'h0; end
      else    begin b_valid = 1'b0; b_wstrb = 4'h0; end
      check("bus_done", 32'(done), 32'h1);
   endtask

   task automatic wr(input bit nb, input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] d;
      int c;
      bus_xfer(nb, addr, wdata, 4'hF, d, c);
   endtask

   task automatic rd_chk(input bit nb, input logic [31:0] addr, input logic [31:0] exp, input string tag);
      logic [31:0] d;
      int c;
      bus_xfer(nb, addr, 32'h0, 4'h0, d, c);
      check(tag, d, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          c;
      bit          seen;

      resetn = 1'b0;
      b_valid = 0; b_addr = 0; b_wdata = 0; b_wstrb = 0; b_val_in = 0; b_din = 0; b_rdy_dn = 0;
      n_valid = 0; n_addr = 0; n_wdata = 0; n_wstrb = 0; n_val_in = 0; n_din = 0; n_rdy_dn = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready_upward_low", 32'(b_rdy_up), 32'h0);
      check("rst_bus_ready_low", 32'(b_ready), 32'h0);
      resetn = 1'b1;
      @(negedge clk);
      check("post_rst_ready_upward", 32'(b_rdy_up), 32'h1F);
      check("post_rst_val_out", 32'(b_val_out), 32'h0);
      check("post_rst_irq", 32'(b_irq), 32'h0);
      check("post_rst_rdata", b_rdata, 32'h0);
      rd_chk(0, BASE + 32'h04, 32'h0000_0002, "status0_reset");

      // RX ordering on port 0
      b_val_in[0] = 1'b1; b_din[31:0] = 32'hA5A5_0001;
      @(negedge clk);
      b_din[31:0] = 32'hA5A5_0002;
      @(negedge clk);
      b_val_in[0] = 1'b0;
      rd_chk(0, BASE + 32'h04, 32'h0000_0203, "status0_two_words");
      rd_chk(0, BASE + 32'h00, 32'hA5A5_0001, "rx0_first");
      rd_chk(0, BASE + 32'h00, 32'hA5A5_0002, "rx0_second");
      rd_chk(0, BASE + 32'h04, 32'h0000_0002, "status0_drained");

      // TX on port 4 with first-word fall-through
      wr(0, BASE + 32'h40, 32'hDEAD_BEEF);
      check("tx4_val_out", 32'(b_val_out[4]), 32'h1);
      check("tx4_dout", b_dout[159:128], 32'hDEAD_BEEF);
      b_rdy_dn[4] = 1'b1;
      @(negedge clk);
      check("tx4_popped", 32'(b_val_out[4]), 32'h0);
      b_rdy_dn[4] = 1'b0;

      // Blocking TX full stall on port 2
      for (int k = 1; k <= 8; k++) wr(0, BASE + 32'h20, 32'hC0DE_0000 + k);
      b_valid = 1'b1; b_addr = BASE + 32'h20; b_wdata = 32'hC0DE_0009; b_wstrb = 4'hF;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (b_ready) seen = 1'b1;
      end
      check("tx2_full_stalls", 32'(seen), 32'h0);
      b_rdy_dn[2] = 1'b1;
      @(negedge clk);
      b_rdy_dn[2] = 1'b0;
      c = 0;
      seen = b_ready;
      while (!seen && c < 4) begin
         @(negedge clk);
         c++;
         seen = b_ready;
      end
      b_valid = 1'b0; b_wstrb = 4'h0;
      check("tx2_ninth_completes", 32'(seen && c <= 2), 32'h1);
      rd_chk(0, BASE + 32'h24, 32'h0008_0000, "status2_full");
      b_rdy_dn[2] = 1'b1;
      for (int k = 2; k <= 9; k++) begin
         check("tx2_drain_order", b_dout[95:64], 32'hC0DE_0000 + k);
         @(negedge clk);
      end
      b_rdy_dn[2] = 1'b0;
      check("tx2_empty", 32'(b_val_out[2]), 32'h0);

      // RX interrupt on port 3
      wr(0, BASE + 32'h38, 32'h1);
      rd_chk(0, BASE + 32'h38, 32'h1, "irq_en3_readback");
      b_val_in[3] = 1'b1; b_din[127:96] = 32'h3333_0001;
      @(negedge clk);
      b_val_in[3] = 1'b0;
      check("irq_lag", 32'(b_irq), 32'h0);
      @(negedge clk);
      check("irq_set", 32'(b_irq), 32'h1);
      rd_chk(0, BASE + 32'h30, 32'h3333_0001, "rx3_data");
      check("irq_hold_at_pop", 32'(b_irq), 32'h1);
      @(negedge clk);
      check("irq_clear", 32'(b_irq), 32'h0);

      // Reserved offsets and address miss
      rd_chk(0, BASE + 32'h0C, 32'h0, "rsvd_0c");
      wr(0, BASE + 32'h50, 32'hFFFF_FFFF);
      rd_chk(0, BASE + 32'h54, 32'h0, "port5_unmapped");
      rd_chk(0, BASE + 32'h44, 32'h0000_0002, "status4_untouched");
      b_valid = 1'b1; b_addr = 32'h2000_0100; b_wstrb = 4'h0;
      #1;
      check("miss_hit_low", 32'(b_hit), 32'h0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (b_ready) seen = 1'b1;
      end
      b_valid = 1'b0;
      check("miss_no_ready", 32'(seen), 32'h0);

      // Non-blocking: empty RX read and sticky underflow on port 1
      bus_xfer(1, BASE + 32'h10, 32'h0, 4'h0, d, c);
      check("nb_underflow_rdata", d, 32'h0);
      check("nb_underflow_latency", 32'(c), 32'h1);
      rd_chk(1, BASE + 32'h14, 32'h0000_000A, "nb_status1_underflow");
      wr(1, BASE + 32'h14, 32'h8);
      rd_chk(1, BASE + 32'h14, 32'h0000_0002, "nb_status1_cleared");

      // Non-blocking: full TX write drops data on port 0
      for (int k = 1; k <= 8; k++) wr(1, BASE + 32'h00, 32'h5500_0000 + k);
      bus_xfer(1, BASE + 32'h00, 32'h5500_0009, 4'hF, d, c);
      check("nb_drop_latency", 32'(c), 32'h1);
      rd_chk(1, BASE + 32'h04, 32'h0008_0004, "nb_status0_drop");
      check("nb_head_kept", n_dout[31:0], 32'h5500_0001);
      wr(1, BASE + 32'h04, 32'h4);
      rd_chk(1, BASE + 32'h04, 32'h0008_0000, "nb_status0_cleared");

      // Reset during a stalled read, with data left in several FIFOs
      b_val_in[0] = 1'b1; b_din[31:0] = 32'h0101_0101;
      b_val_in[3] = 1'b1; b_din[127:96] = 32'h0303_0303;
      @(negedge clk);
      b_val_in = '0;
      wr(0, BASE + 32'h40, 32'h4444_4444);
      @(negedge clk);
      check("pre_rst_irq", 32'(b_irq), 32'h1);
      b_valid = 1'b1; b_addr = BASE + 32'h10; b_wstrb = 4'h0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (b_ready) seen = 1'b1;
      end
      resetn = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (b_ready) seen = 1'b1;
      end
      check("mid_rst_ready_upward", 32'(b_rdy_up), 32'h0);
      b_valid = 1'b0;
      resetn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (b_ready) seen = 1'b1;
      end
      check("stall_rst_no_ready", 32'(seen), 32'h0);
      check("rst_flush_val_out", 32'(b_val_out), 32'h0);
      check("rst_flush_nb_val_out", 32'(n_val_out), 32'h0);
      check("rst_ready_upward_back", 32'(b_rdy_up), 32'h1F);
      check("rst_irq_cleared", 32'(b_irq), 32'h0);
      rd_chk(0, BASE + 32'h04, 32'h0000_0002, "rst_status0_empty");
      rd_chk(0, BASE + 32'h34, 32'h0000_0002, "rst_status3_empty");
      rd_chk(0, BASE + 32'h38, 32'h0, "rst_irq_en3_cleared");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
